// File: rtl/uop_warp_ibuffer_if.sv
// Handshake bundle between the micro-op sequencer, the per-warp ibuffer and issue.
// master drives pushes, flushes and out_ready; slave is the buffer itself.
interface uop_warp_ibuffer_if #(
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 128,
  parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
  logic                 in_valid;
  logic [WID_W-1:0]     in_wid;
  logic [DATAW-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WID_W-1:0]     out_wid;
  logic [DATAW-1:0]     out_data;
  logic                 out_ready;
  logic                 flush_valid;
  logic [WID_W-1:0]     flush_wid;
  logic [NUM_WARPS-1:0] warp_empty;
  logic [NUM_WARPS-1:0] warp_full;

  modport master (
    output in_valid, in_wid, in_data, out_ready, flush_valid, flush_wid,
    input  in_ready, out_valid, out_wid, out_data, warp_empty, warp_full
  );

  modport slave (
    input  in_valid, in_wid, in_data, out_ready, flush_valid, flush_wid,
    output in_ready, out_valid, out_wid, out_data, warp_empty, warp_full
  );
endinterface

// File: rtl/uop_warp_ibuffer.sv
// Per-warp instruction buffer: one FIFO per warp, round-robin head selection
// toward issue, per-warp flush. All outputs are combinational from state + inputs.
module uop_warp_ibuffer_lane #(
  parameter int DEPTH = 4,
  parameter int DATAW = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [DATAW-1:0] push_data,
  output logic             empty,
  output logic             full,
  output logic [DATAW-1:0] head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][DATAW-1:0] mem;
  logic [PTR_W-1:0]            rd_ptr, wr_ptr, wr_nxt;
  logic [CNT_W-1:0]            count;

  assign wr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      if (flush) begin
        // flush wins over a same-cycle pop: queue collapses to the write side
        rd_ptr <= wr_nxt;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // payload storage needs no reset; validity lives in count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_data = mem[rd_ptr];
endmodule

module uop_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 128,
  parameter int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  uop_warp_ibuffer_if.slave     bus
);
  localparam logic [WID_W:0] NW = NUM_WARPS[WID_W:0];

  logic [NUM_WARPS-1:0]            cand, empty_v, full_v;
  logic [NUM_WARPS-1:0][DATAW-1:0] head_data;
  logic [WID_W-1:0]                win, rr_ptr;
  logic                            in_wid_ok, push_fire, pop_fire, flush_hit_in;

  assign bus.warp_empty = empty_v;
  assign bus.warp_full  = full_v;
  assign cand           = ~empty_v;

  assign in_wid_ok    = ({1'b0, bus.in_wid} < NW);
  assign flush_hit_in = bus.flush_valid && (bus.flush_wid == bus.in_wid);
  assign bus.in_ready = in_wid_ok && !full_v[bus.in_wid] && !flush_hit_in;
  assign push_fire    = bus.in_valid && bus.in_ready;

  // first non-empty warp at or above rr_ptr, wrapping
  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = WID_W'(idx);
      end
    end
  end

  assign bus.out_valid = |cand;
  assign bus.out_wid   = win;
  assign bus.out_data  = head_data[win];
  assign pop_fire      = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        rr_ptr <= '0;
    else if (pop_fire) rr_ptr <= ({1'b0, win} == NW - 1'b1) ? '0 : win + WID_W'(1);
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    uop_warp_ibuffer_lane #(.DEPTH(DEPTH), .DATAW(DATAW)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .push      (push_fire && (bus.in_wid == WID_W'(w))),
      .pop       (pop_fire && (win == WID_W'(w))),
      .flush     (bus.flush_valid && (bus.flush_wid == WID_W'(w))),
      .push_data (bus.in_data),
      .empty     (empty_v[w]),
      .full      (full_v[w]),
      .head_data (head_data[w])
    );
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push_fire && full_v[bus.in_wid]));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(pop_fire && empty_v[win]));
  a_flush_wid:    assert property (@(posedge clk) disable iff (!reset)
    !(bus.flush_valid && !({1'b0, bus.flush_wid} < NW)));
`endif
endmodule

// File: tb/tb_uop_warp_ibuffer.sv
// Directed + random bench for uop_warp_ibuffer against a queue-based warp model.
module tb_uop_warp_ibuffer;
  localparam int NW    = 4;
  localparam int DEPTH = 4;
  localparam int DATAW = 128;
  localparam int WID_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  uop_warp_ibuffer_if #(.NUM_WARPS(NW), .DATAW(DATAW), .WID_W(WID_W)) bus ();

  uop_warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(DATAW), .WID_W(WID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model: one queue per warp plus the round-robin start point
  logic [DATAW-1:0] q [NW][$];
  int rr = 0;

  task automatic chk(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) q[w].delete();
    rr = 0;
  endtask

  // one clock: drive, check at negedge against the model, advance model, pass posedge
  task automatic cycle(input logic iv, input int iw, input logic [DATAW-1:0] id,
                       input logic ordy, input logic fv, input int fw);
    logic         e_valid, e_rdy;
    int           e_win;
    logic [NW-1:0] e_empty, e_full;
    bus.in_valid    = iv;
    bus.in_wid      = WID_W'(iw);
    bus.in_data     = id;
    bus.out_ready   = ordy;
    bus.flush_valid = fv;
    bus.flush_wid   = WID_W'(fw);
    @(negedge clk);
    e_valid = 1'b0;
    e_win   = 0;
    for (int i = 0; i < NW; i++) begin
      e_empty[i] = (q[i].size() == 0);
      e_full[i]  = (q[i].size() == DEPTH);
      if (!e_valid && q[(rr + i) % NW].size() != 0) begin
        e_valid = 1'b1;
        e_win   = (rr + i) % NW;
      end
    end
    e_rdy = (q[iw].size() != DEPTH) && !(fv && fw == iw);
    chk("out_valid",  bus.out_valid,  e_valid);
    chk("warp_empty", bus.warp_empty, e_empty);
    chk("warp_full",  bus.warp_full,  e_full);
    chk("in_ready",   bus.in_ready,   e_rdy);
    if (e_valid) begin
      chk("out_wid",  bus.out_wid,  e_win);
      chk("out_data", bus.out_data, q[e_win][0]);
    end
    if (reset) begin
      if (e_valid && ordy) begin
        void'(q[e_win].pop_front());
        rr = (e_win + 1) % NW;
      end
      if (iv && e_rdy) q[iw].push_back(id);
      if (fv) q[fw].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 0, '0, ordy, 1'b0, 0);
  endtask

  task automatic push(input int w, input logic [DATAW-1:0] d);
    cycle(1'b1, w, d, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [DATAW-1:0] rd;
    model_clear();
    // reset held for three cycles
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("rst_empty", bus.warp_empty, 4'b1111);
    reset = 1'b1;

    push(1, 128'hA1);
    chk("a1_valid", bus.out_valid, 1'b1);
    chk("a1_wid",   bus.out_wid,   2'd1);
    chk("a1_data",  bus.out_data,  128'hA1);
    idle(1'b1);

    // fill warp2, reject a fifth, still accept warp0, then drain interleaved
    for (int i = 0; i < 4; i++) push(2, 128'h10 + i);
    chk("w2_full", bus.warp_full[2], 1'b1);
    push(2, 128'h14);
    push(0, 128'h20);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("drain_empty", bus.warp_empty, 4'b1111);

    // round robin from a fresh reset
    reset = 1'b0;
    model_clear();
    idle(1'b0);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(0, 128'h100 + k);
      push(1, 128'h200 + k);
      push(3, 128'h300 + k);
    end
    for (int k = 0; k < 6; k++) begin
      chk("rr_seq", bus.out_wid, seq[k]);
      idle(1'b1);
    end
    chk("rr_done", bus.out_valid, 1'b0);

    // simultaneous push and pop on warp0
    push(0, 128'h50);
    cycle(1'b1, 0, 128'h55, 1'b1, 1'b0, 0);
    chk("pp_data",  bus.out_data, 128'h55);
    chk("pp_count", bus.warp_empty[0], 1'b0);
    idle(1'b1);

    // flush warp3 during its pop, with a blocked push to warp3
    push(2, 128'h2A);
    for (int i = 0; i < 3; i++) push(3, 128'h30 + i);
    cycle(1'b1, 1, 128'h40, 1'b1, 1'b0, 0);
    chk("fl_win", bus.out_wid, 2'd3);
    cycle(1'b1, 3, 128'h99, 1'b1, 1'b1, 3);
    chk("fl_empty3", bus.warp_empty[3], 1'b1);
    chk("fl_wid",    bus.out_wid, 2'd1);
    chk("fl_data",   bus.out_data, 128'h40);
    idle(1'b1);

    // wrap-around: 10 push/pop pairs on warp1
    for (int i = 0; i < 10; i++) begin
      push(1, DATAW'(i));
      chk("wrap_data", bus.out_data, DATAW'(i));
      idle(1'b1);
    end
    chk("wrap_empty", bus.warp_empty[1], 1'b1);

    // asynchronous reset mid-traffic discards everything
    push(0, 128'hE0);
    push(2, 128'hE2);
    reset = 1'b0;
    #2;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_empty", bus.warp_empty, 4'b1111);
    model_clear();
    idle(1'b0);
    reset = 1'b1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, NW - 1), rd,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom_range(0, NW - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
